alu_wide_seq: RTL
=================

Name: alu_wide_seq

Overview:
- Multi-precision sequencer on the initiator side of the 8-bit ALU interface. It drives OP/INPUTA/INPUTB/SC_IN and consumes OUT/SC_OUT/ZERO.
- Splits one wide operation (NWORDS bytes) into byte-serial ALU passes, LSW first, and chains carry through a register.
- Accumulates the wide result, carry and zero flag, then reports completion with a start/done handshake.
- Sits between the control unit and the ALU for 16-bit (and wider) arithmetic and logic.

Parameters:
- NWORDS, 2, operand width in bytes; legal range 2..4; operand/result width W = 8*NWORDS.

Ports:
- CLK, input, 1, system clock; all state changes on its rising edge.
- RST_N, input, 1, asynchronous active-low reset.
- START, input, 1, request a wide operation; sampled only in IDLE.
- OPCODE, input, 3, operation in op_mne encoding from the definitions package (kADD, kXOR, kAND, kGBT).
- CIN, input, 1, carry-in to byte 0 for kADD.
- A_IN, input, W, operand A; latched on accept.
- B_IN, input, W, operand B; latched on accept.
- BUSY, output, 1, high while bytes are being processed.
- DONE, output, 1, one-cycle completion pulse.
- RESULT, output, W, wide result; held until the next accept.
- CARRY, output, 1, final carry out.
- ZERO, output, 1, high when the whole W-bit RESULT is 0.
- ALU_OP, output, 3, to ALU OP.
- ALU_A, output, 8, to ALU INPUTA.
- ALU_B, output, 8, to ALU INPUTB.
- ALU_SC_IN, output, 1, to ALU SC_IN.
- ALU_OUT, input, 8, from ALU OUT.
- ALU_SC_OUT, input, 1, from ALU SC_OUT.
- ALU_ZERO, input, 1, from ALU ZERO.

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE, byte index=0, carry reg=0.
  - BUSY=0, DONE=0, RESULT=0, CARRY=0, ZERO=0.
  - ALU_OP=0, ALU_A=0, ALU_B=0, ALU_SC_IN=0.
  - Reset mid-operation aborts the operation; no DONE is produced.
- States:
  - IDLE:
    - START=1 at edge T: latch OPCODE, A_IN, B_IN; carry reg <= CIN; index <= 0; zero-accumulator <= 1; RESULT cleared to 0; go RUN.
    - START=0: stay in IDLE.
  - RUN:
    - Combinationally drive ALU_OP = latched opcode, ALU_A = A[8*i+:8], ALU_B = B[8*i+:8], ALU_SC_IN = carry reg.
    - Each edge: RESULT[8*i+:8] <= ALU_OUT; carry reg <= ALU_SC_OUT; zero-acc <= zero-acc & ALU_ZERO; i <= i+1.
    - After byte NWORDS-1 is captured, go DONE.
  - DONE:
    - DONE=1 for exactly one cycle; CARRY <= final carry reg; ZERO <= zero-acc; then go IDLE.
- Timing: accept at edge T; BUSY=1 during cycles T+1..T+NWORDS; DONE=1 in cycle T+NWORDS+1; total latency NWORDS+1 cycles. For NWORDS=2, DONE is high 3 cycles after the accept edge.
- ALU outputs in IDLE/DONE: ALU_A=0, ALU_B=0, ALU_SC_IN=0, ALU_OP=0.
- Opcode rules:
  - kADD: carry propagates byte to byte.
  - kXOR, kAND: ALU returns SC_OUT=0, so CARRY=0.
  - kGBT: byte 0 is processed normally (RESULT[0]=A[0]). Bytes 1..NWORDS-1 are forced to RESULT=0 and treated as zero regardless of the ALU response, so RESULT = {0..., A[0]} and ZERO = ~A[0].
  - Undefined opcode: ALU returns 0, giving RESULT=0, CARRY=0, ZERO=1.
- Boundaries:
  - START while BUSY or in DONE is ignored; it is not queued.
  - START held high continuously starts a new operation on the first IDLE edge after DONE.
  - A_IN/B_IN/OPCODE/CIN changing after accept have no effect.
  - Index never exceeds NWORDS-1; no wrap into stale bytes.
  - RESULT/CARRY/ZERO remain stable from DONE until the next accept.

Test Plan:
- NWORDS=2, kADD, A=0x00FF, B=0x0001, CIN=0 -> RESULT=0x0100, CARRY=0, ZERO=0; DONE exactly 3 cycles after the accept edge; BUSY high 2 cycles.
- kADD, A=0xFFFF, B=0x0001, CIN=0 -> RESULT=0x0000, CARRY=1, ZERO=1. Same operands with CIN=1 and B=0x0000 -> RESULT=0x0000, CARRY=1, ZERO=1.
- kXOR, A=0xA55A, B=0xA55A -> RESULT=0x0000, ZERO=1, CARRY=0. Then kAND, A=0xF0F0, B=0x3C3C -> RESULT=0x3030, ZERO=0.
- kGBT, A=0x1235 -> RESULT=0x0001, ZERO=0. kGBT, A=0xFF34 -> RESULT=0x0000, ZERO=1, CARRY=0.
- START pulsed at cycles T+1 and T+2 during a kADD 0x1234+0x1111 -> single DONE, RESULT=0x2345; the extra STARTs are ignored.
- RST_N low at cycle T+1 of an operation -> BUSY=0, RESULT=0, no DONE. After reset release, a new kADD 0x0001+0x0001 -> RESULT=0x0002.

Source files
------------

// File: rtl/alu_wide_seq.sv
// alu_wide_seq: byte-serial multi-precision sequencer driving the 8-bit ALU.
// One wide op is split into NWORDS ALU passes, LSB first, carry chained.
package alu_defs_pkg;
  typedef enum logic [2:0] {
    kADD = 3'd0,
    kXOR = 3'd1,
    kAND = 3'd2,
    kGBT = 3'd3
  } op_mne;
endpackage

module alu_wide_seq
  import alu_defs_pkg::*;
#(
  parameter int NWORDS = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                START,
  input  logic [2:0]          OPCODE,
  input  logic                CIN,
  input  logic [8*NWORDS-1:0] A_IN,
  input  logic [8*NWORDS-1:0] B_IN,
  output logic                BUSY,
  output logic                DONE,
  output logic [8*NWORDS-1:0] RESULT,
  output logic                CARRY,
  output logic                ZERO,
  output logic [2:0]          ALU_OP,
  output logic [7:0]          ALU_A,
  output logic [7:0]          ALU_B,
  output logic                ALU_SC_IN,
  input  logic [7:0]          ALU_OUT,
  input  logic                ALU_SC_OUT,
  input  logic                ALU_ZERO
);

  localparam int W  = 8 * NWORDS;
  localparam int IW = $clog2(NWORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            cy_q, cy_d;
  logic            zacc_q, zacc_d;
  logic [2:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    res_q, res_d;
  logic            carry_q, carry_d;
  logic            zero_q, zero_d;
  logic [7:0]      byte_v;
  logic            bz;
  logic            last;
  logic [IW+2:0]   bit_off;

  assign bit_off = {idx_q, 3'b000};
  assign last    = (idx_q == IW'(NWORDS - 1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cy_d      = cy_q;
    zacc_d    = zacc_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    ALU_OP    = 3'd0;
    ALU_A     = 8'd0;
    ALU_B     = 8'd0;
    ALU_SC_IN = 1'b0;
    byte_v    = ALU_OUT;
    bz        = ALU_ZERO;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (START) begin
          op_d    = OPCODE;
          a_d     = A_IN;
          b_d     = B_IN;
          cy_d    = CIN;
          idx_d   = '0;
          zacc_d  = 1'b1;
          res_d   = '0;
          state_d = S_RUN;
        end
      end
      (state_q == S_RUN): begin
        ALU_OP    = op_q;
        ALU_A     = a_q[bit_off +: 8];
        ALU_B     = b_q[bit_off +: 8];
        ALU_SC_IN = cy_q;
        // Get-bit yields a single byte; upper bytes are forced to zero
        if (op_q == kGBT && idx_q != '0) begin
          byte_v = 8'd0;
          bz     = 1'b1;
        end
        res_d[bit_off +: 8] = byte_v;
        cy_d   = ALU_SC_OUT;
        zacc_d = zacc_q & bz;
        if (last) begin
          carry_d = ALU_SC_OUT;
          zero_d  = zacc_q & bz;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      (state_q == S_DONE): begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      zacc_q  <= 1'b0;
      op_q    <= 3'd0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      zacc_q  <= zacc_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign BUSY   = (state_q == S_RUN);
  assign DONE   = (state_q == S_DONE);
  assign RESULT = res_q;
  assign CARRY  = carry_q;
  assign ZERO   = zero_q;

endmodule
